// File: rtl/configurations.sv
// Shared platform constants and bus types used by the memory-mapped
// simulation peripherals.
package configurations;

  localparam logic [63:0] STDIN_BASE_ADDR = 64'h0000_0000_1000_0100;

  typedef enum logic [2:0] {
    NO_STORE,
    STORE_BYTE,
    STORE_HALF,
    STORE_WORD,
    STORE_DOUBLE
  } mem_store_type_t;

endpackage

// File: rtl/stdin_mmio.sv
// Simulation console input: the host pushes characters into a FIFO, and the
// CPU pops them through a DATA register and polls a STAT register.
module stdin_mmio #(
  parameter logic [63:0] BASE_ADDR = configurations::STDIN_BASE_ADDR,
  parameter int          DEPTH     = 16
) (
  input  logic                              clock,
  input  logic                              reset,
  input  logic                              enable,
  input  logic [63:0]                       addr,
  input  logic                              mem_read,
  input  configurations::mem_store_type_t   mem_store_type,
  input  logic                              host_valid,
  input  logic [7:0]                        host_data,
  output logic                              host_ready,
  output logic [63:0]                       r_data,
  output logic                              stdin_taken
);

  localparam int          AW         = $clog2(DEPTH);
  localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);
  localparam logic [AW:0] ONE        = (AW+1)'(1);
  localparam logic [63:0] STAT_ADDR  = BASE_ADDR + 64'd8;
  localparam logic [63:0] END_ADDR   = BASE_ADDR + 64'd16;

  logic [7:0]    fifo_mem [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [AW:0]   count;
  logic          underflow;

  logic          empty;
  logic          full;
  logic          data_hit;
  logic          stat_hit;
  logic          push;
  logic          pop;
  logic          clear_uf;
  logic          set_uf;
  logic [7:0]    head;

  assign empty      = (count == '0);
  assign full       = (count == FULL_COUNT);
  assign host_ready = !full;

  assign data_hit = enable && (addr >= BASE_ADDR) && (addr < STAT_ADDR);
  assign stat_hit = enable && (addr >= STAT_ADDR) && (addr < END_ADDR);

  // Readiness comes from the pre-edge full flag, so a pop cannot make room
  // for a push in the same cycle.
  assign push     = host_valid && host_ready;
  assign pop      = data_hit && mem_read && !empty;
  assign set_uf   = data_hit && mem_read && empty;
  assign clear_uf = stat_hit && (mem_store_type != configurations::NO_STORE);

  assign head = empty ? 8'h00 : fifo_mem[rd_ptr];

  always_comb begin
    r_data = 64'd0;
    if (data_hit && mem_read) begin
      r_data = {8{head}};
    end else if (stat_hit && mem_read) begin
      r_data = {45'd0, underflow, full, empty, 16'(count)};
    end
  end

  always_ff @(posedge clock) begin
    if (push) begin
      fifo_mem[wr_ptr] <= host_data;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      count       <= '0;
      underflow   <= 1'b0;
      stdin_taken <= 1'b0;
    end else begin
      stdin_taken <= data_hit || stat_hit;
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + ONE;
        2'b01:   count <= count - ONE;
        default: count <= count;
      endcase
      // A clearing store wins over an underflowing load in the same cycle.
      if (clear_uf) begin
        underflow <= 1'b0;
      end else if (set_uf) begin
        underflow <= 1'b1;
      end
    end
  end

endmodule
